gfx_double_buffer: RTL and testbench

Double-buffered GBA frame store between the graphics pipeline and the VGA output stage. The pipeline writes 15-bit BGR555 pixels by (row, col) into the back buffer. The VGA stage reads the front buffer by linear address with one-cycle synchronous latency. Buffers swap only during the vertical sync pulse, after the pipeline has declared the frame complete, so the display never shows a partially drawn frame.

---
 rtl/gfx_fb_pkg.sv | 22 ++
 rtl/fb_ram.sv | 35 +++
 rtl/gfx_double_buffer.sv | 165 ++++++++++++++++
 tb/tb_gfx_double_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gfx_fb_pkg.sv
// gfx_fb_pkg: shared constants and types for the GBA double-buffered frame store.
//   GBA_ROWS / GBA_COLS / GBA_PIXELS : visible frame geometry
//   pixel_t                          : BGR555 pixel ([14:10] B, [9:5] G, [4:0] R)
//   fb_addr_t                        : linear frame-store address (row*COLS+col)
//   fb_state_e                       : buffer-swap control state
package gfx_fb_pkg;

    localparam int unsigned GBA_ROWS   = 160;
    localparam int unsigned GBA_COLS   = 240;
    localparam int unsigned GBA_PIXELS = GBA_ROWS * GBA_COLS;

    typedef logic [14:0] pixel_t;
    typedef logic [16:0] fb_addr_t;

    // FB_DRAWING: back buffer open for writes.
    // FB_PENDING: frame complete, waiting for vsync to swap.
    typedef enum logic {
        FB_DRAWING = 1'b0,
        FB_PENDING = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port frame buffer, DEPTH x DATA_W, no reset.
//   clock   : single clock for both ports
//   we      : write enable, commits wr_data at wr_idx on the rising edge
//   wr_idx  : write index
//   wr_data : write data
//   rd_idx  : read index, data appears on rd_data one cycle later
//   rd_data : registered read data
module fb_ram
    import gfx_fb_pkg::*;
#(
    parameter int unsigned DEPTH  = GBA_PIXELS,
    parameter int unsigned DATA_W = 15,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        rd_q <= mem[rd_idx];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/gfx_double_buffer.sv
// gfx_double_buffer: double-buffered GBA frame store between the graphics
// pipeline (writer) and the VGA output stage (reader).
//   clock, reset : single clock, asynchronous active-high reset
//   wr_en/wr_row/wr_col/wr_data : pixel write into the back buffer
//   wr_ready     : back buffer accepts writes (no swap pending)
//   frame_done   : one-cycle pulse, last pixel of the frame issued
//   vga_vs       : VGA vertical sync, active-low; swaps happen on its falling edge
//   rd_addr      : linear front-buffer read address
//   rd_data      : front-buffer pixel, one cycle after rd_addr (0 if out of range)
//   front_sel    : buffer currently displayed
//   frame_count  : swaps since reset, wrapping
//   overrun      : sticky, in-range write arrived while wr_ready=0
module gfx_double_buffer
    import gfx_fb_pkg::*;
#(
    parameter int unsigned ROWS   = GBA_ROWS,
    parameter int unsigned COLS   = GBA_COLS,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_row,
    input  logic [7:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_done,
    input  logic              vga_vs,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              front_sel,
    output logic [7:0]        frame_count,
    output logic              overrun
);

    localparam int unsigned PIXELS = ROWS * COLS;
    localparam int unsigned IDX_W  = $clog2(PIXELS);

    fb_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic [7:0]        count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              vs_q, vs_d;
    logic              wv_q, wv_d;
    logic [IDX_W-1:0]  wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              wb_q, wb_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_zero_q, rd_zero_d;

    fb_addr_t          row_ext;
    fb_addr_t          wr_addr_full;
    logic              wr_in_range;
    logic              swap_edge;
    logic              unused_addr_hi;
    logic [DATA_W-1:0] ram0_q, ram1_q;

    always_comb begin
        // row*240 as shifts, evaluated at full address width
        row_ext      = fb_addr_t'(wr_row);
        wr_addr_full = (row_ext << 8) - (row_ext << 4) + fb_addr_t'(wr_col);
        wr_in_range  = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
        swap_edge    = vs_q & ~vga_vs;

        state_d   = state_q;
        front_d   = front_q;
        count_d   = count_q;
        vs_d      = vga_vs;

        // Write stage: buffer index is captured with the pixel so a swap
        // between acceptance and commit still lands it in the right buffer.
        wv_d      = wr_en && wr_in_range && (state_q == FB_DRAWING);
        wa_d      = wr_addr_full[IDX_W-1:0];
        wd_d      = wr_data;
        wb_d      = ~front_q;
        ovr_d     = ovr_q | (wr_en && wr_in_range && (state_q == FB_PENDING));

        // Read stage: buffer select travels with the address.
        rd_sel_d  = front_q;
        rd_zero_d = (32'(rd_addr) >= PIXELS);

        unique case (state_q)
            FB_DRAWING: begin
                if (frame_done) begin
                    state_d = FB_PENDING;
                end
            end
            FB_PENDING: begin
                if (swap_edge) begin
                    state_d = FB_DRAWING;
                    front_d = ~front_q;
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = FB_DRAWING;
        endcase
    end

    // Out-of-range writes are filtered before the index is truncated.
    assign unused_addr_hi = |wr_addr_full[$bits(fb_addr_t)-1:IDX_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FB_DRAWING;
            front_q   <= 1'b0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            vs_q      <= 1'b1;
            wv_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            wb_q      <= 1'b0;
            rd_sel_q  <= 1'b0;
            // Forces rd_data to 0 until the first real read, since RAM
            // contents are not reset.
            rd_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            front_q   <= front_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            vs_q      <= vs_d;
            wv_q      <= wv_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            wb_q      <= wb_d;
            rd_sel_q  <= rd_sel_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    fb_ram #(
        .DEPTH  (PIXELS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram0 (
        .clock   (clock),
        .we      (wv_q & ~wb_q),
        .wr_idx  (wa_q),
        .wr_data (wd_q),
        .rd_idx  (rd_addr[IDX_W-1:0]),
        .rd_data (ram0_q)
    );

    fb_ram #(
        .DEPTH  (PIXELS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram1 (
        .clock   (clock),
        .we      (wv_q & wb_q),
        .wr_idx  (wa_q),
        .wr_data (wd_q),
        .rd_idx  (rd_addr[IDX_W-1:0]),
        .rd_data (ram1_q)
    );

    assign rd_data     = rd_zero_q ? '0 : (rd_sel_q ? ram1_q : ram0_q);
    assign wr_ready    = (state_q == FB_DRAWING);
    assign front_sel   = front_q;
    assign frame_count = count_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_gfx_double_buffer.sv
// tb_gfx_double_buffer: directed self-checking bench for gfx_double_buffer.
module tb_gfx_double_buffer;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_row;
    logic [7:0]  wr_col;
    logic [14:0] wr_data;
    logic        wr_ready;
    logic        frame_done;
    logic        vga_vs;
    logic [16:0] rd_addr;
    logic [14:0] rd_data;
    logic        front_sel;
    logic [7:0]  frame_count;
    logic        overrun;

    int unsigned n_checks;
    int unsigned n_pass;

    gfx_double_buffer #(
        .ROWS   (160),
        .COLS   (240),
        .ADDR_W (17),
        .DATA_W (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_done  (frame_done),
        .vga_vs      (vga_vs),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .front_sel   (front_sel),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_px(input logic [7:0] row, input logic [7:0] col, input logic [14:0] data);
        wr_en   = 1'b1;
        wr_row  = row;
        wr_col  = col;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic rd_px(input logic [16:0] addr);
        rd_addr = addr;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_row     = '0;
        wr_col     = '0;
        wr_data    = '0;
        frame_done = 1'b0;
        vga_vs     = 1'b1;
        rd_addr    = '0;

        repeat (3) tick();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_front", 32'(front_sel), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_count", 32'(frame_count), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick();

        // Frame 1 into buffer 1; out-of-range writes are ignored silently.
        wr_px(8'd160, 8'd0, 15'h2AAA);
        wr_px(8'd0, 8'd240, 15'h3333);
        check("oob_no_overrun", 32'(overrun), 32'h0);
        wr_px(8'd1, 8'd2, 15'h7FFF);
        pulse_done();
        check("f1_pending_ready", 32'(wr_ready), 32'h0);
        vga_vs = 1'b0;
        tick();
        check("f1_front", 32'(front_sel), 32'h1);
        check("f1_count", 32'(frame_count), 32'h1);
        check("f1_ready", 32'(wr_ready), 32'h1);
        vga_vs = 1'b1;
        tick();
        rd_px(17'd242);
        check("f1_rd242", 32'(rd_data), 32'h7FFF);

        // Vsync without frame_done: hold and re-show the frame.
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
        tick();
        check("nodone_front", 32'(front_sel), 32'h1);
        check("nodone_count", 32'(frame_count), 32'h1);
        rd_px(17'd242);
        check("nodone_rd242", 32'(rd_data), 32'h7FFF);

        // Frame 2 into buffer 0.
        wr_px(8'd0, 8'd0, 15'h0ABC);
        wr_px(8'd1, 8'd0, 15'h0777);
        wr_px(8'd0, 8'd240, 15'h3333);
        wr_px(8'd2, 8'd3, 15'h0155);
        wr_px(8'd159, 8'd239, 15'h1111);
        // frame_done coincident with the vsync edge: no swap yet.
        frame_done = 1'b1;
        vga_vs     = 1'b0;
        tick();
        frame_done = 1'b0;
        check("coinc_front", 32'(front_sel), 32'h1);
        check("coinc_count", 32'(frame_count), 32'h1);
        check("coinc_ready", 32'(wr_ready), 32'h0);
        vga_vs = 1'b1;
        tick();
        wr_px(8'd160, 8'd0, 15'h2222);
        check("pend_oob_overrun", 32'(overrun), 32'h0);
        wr_px(8'd0, 8'd0, 15'h1234);
        check("pend_overrun", 32'(overrun), 32'h1);
        vga_vs = 1'b0;
        tick();
        check("f2_front", 32'(front_sel), 32'h0);
        check("f2_count", 32'(frame_count), 32'h2);
        vga_vs = 1'b1;
        tick();
        rd_px(17'd0);
        check("f2_rd0", 32'(rd_data), 32'h0ABC);
        rd_px(17'd240);
        check("f2_rd240", 32'(rd_data), 32'h0777);
        rd_px(17'd483);
        check("f2_rd483", 32'(rd_data), 32'h0155);
        rd_px(17'd38399);
        check("f2_rd38399", 32'(rd_data), 32'h1111);

        // Frame 3 into buffer 1; read in flight across the swap.
        wr_px(8'd159, 8'd239, 15'h4321);
        pulse_done();
        vga_vs  = 1'b0;
        rd_addr = 17'd38399;
        tick();
        check("ovl_front", 32'(front_sel), 32'h1);
        check("ovl_count", 32'(frame_count), 32'h3);
        check("ovl_old_data", 32'(rd_data), 32'h1111);
        vga_vs = 1'b1;
        tick();
        check("ovl_new_data", 32'(rd_data), 32'h4321);
        rd_px(17'd242);
        check("tp_rd242", 32'(rd_data), 32'h7FFF);
        rd_px(17'd38400);
        check("rd_oob", 32'(rd_data), 32'h0);
        rd_px(17'd242);
        check("rd_after_oob", 32'(rd_data), 32'h7FFF);
        pulse_done();
        check("pre_rst_ready", 32'(wr_ready), 32'h0);

        // Asynchronous reset mid-stream, checked before any clock edge.
        reset = 1'b1;
        #2;
        check("arst_rd_data", 32'(rd_data), 32'h0);
        check("arst_front", 32'(front_sel), 32'h0);
        check("arst_ready", 32'(wr_ready), 32'h1);
        check("arst_count", 32'(frame_count), 32'h0);
        check("arst_overrun", 32'(overrun), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_front", 32'(front_sel), 32'h0);
        check("post_rst_ready", 32'(wr_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
